// File: rtl/oldland_mem_arbiter_if.sv
// Bundle of the fetch, LSU and memory-bus signals around oldland_mem_arbiter.
// master = the arbiter's view; slave = the requesters plus memory slave.
interface oldland_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_data;
  logic        i_error;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_wr_en;
  logic [1:0]  d_width;
  logic [31:0] d_wr_data;
  logic        d_ack;
  logic [31:0] d_data;
  logic        d_error;

  logic        m_access;
  logic [31:0] m_addr;
  logic        m_wr_en;
  logic [3:0]  m_bytesel;
  logic [31:0] m_wr_data;
  logic        m_ack;
  logic [31:0] m_data;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_wr_en, d_width, d_wr_data, m_ack, m_data,
    output i_ack, i_data, i_error, d_ack, d_data, d_error,
           m_access, m_addr, m_wr_en, m_bytesel, m_wr_data
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_wr_en, d_width, d_wr_data, m_ack, m_data,
    input  i_ack, i_data, i_error, d_ack, d_data, d_error,
           m_access, m_addr, m_wr_en, m_bytesel, m_wr_data
  );
endinterface

// File: rtl/oldland_mem_arbiter.sv
// Round-robin arbiter sharing the Oldland memory bus between fetch and LSU.
// Optional bus timeout: define OLDLAND_ARB_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module oldland_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  oldland_mem_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS_I = 2'd1;
  localparam logic [1:0] S_BUS_D = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;   // 1 = data side had the last grant
  logic [1:0]  width_q, width_d;
  logic [1:0]  lane_q, lane_d;

  logic        m_access_q, m_access_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic        m_wr_en_q, m_wr_en_d;
  logic [3:0]  m_bytesel_q, m_bytesel_d;
  logic [31:0] m_wr_data_q, m_wr_data_d;

  logic        i_ack_q, i_ack_d;
  logic [31:0] i_data_q, i_data_d;
  logic        i_error_q, i_error_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_error_q, d_error_d;

  logic        grant_data;
  logic        timeout_hit;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.i_addr[1:0];

  function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] a);
    case (width)
      2'b10:   lane_mask = 4'b1111;
      2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b0001 << a;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] wdata);
    case (width)
      2'b10:   lane_data = wdata;
      2'b01:   lane_data = {2{wdata[15:0]}};
      default: lane_data = {4{wdata[7:0]}};
    endcase
  endfunction

  function automatic logic [31:0] read_align(input logic [1:0] width, input logic [1:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] r;
    r = rdata;
    case (width)
      2'b10: r = rdata;
      2'b01: r = a[1] ? {16'h0, rdata[31:16]} : {16'h0, rdata[15:0]};
      default: begin
        case (a)
          2'd0:    r = {24'h0, rdata[7:0]};
          2'd1:    r = {24'h0, rdata[15:8]};
          2'd2:    r = {24'h0, rdata[23:16]};
          default: r = {24'h0, rdata[31:24]};
        endcase
      end
    endcase
    return r;
  endfunction

`ifdef OLDLAND_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Only grant leaves IDLE, so clearing there is equivalent to clearing on grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == S_BUS_I || state_q == S_BUS_D) && !bus.m_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_BUS_I || state_q == S_BUS_D) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_param_bit;
  assign unused_param_bit = TIMEOUT_CYCLES[0];
  assign timeout_hit      = 1'b0;
`endif

  // Round robin on contention: the side that did not win last time.
  assign grant_data = bus.d_req && (!bus.i_req || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    width_d      = width_q;
    lane_d       = lane_q;
    m_access_d   = m_access_q;
    m_addr_d     = m_addr_q;
    m_wr_en_d    = m_wr_en_q;
    m_bytesel_d  = m_bytesel_q;
    m_wr_data_d  = m_wr_data_q;
    i_ack_d      = 1'b0;
    i_data_d     = i_data_q;
    i_error_d    = 1'b0;
    d_ack_d      = 1'b0;
    d_data_d     = d_data_q;
    d_error_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d      = S_BUS_D;
          last_grant_d = 1'b1;
          width_d      = bus.d_width;
          lane_d       = bus.d_addr[1:0];
          m_access_d   = 1'b1;
          m_addr_d     = {bus.d_addr[31:2], 2'b00};
          m_wr_en_d    = bus.d_wr_en;
          m_bytesel_d  = lane_mask(bus.d_width, bus.d_addr[1:0]);
          m_wr_data_d  = lane_data(bus.d_width, bus.d_wr_data);
        end else if (bus.i_req) begin
          state_d      = S_BUS_I;
          last_grant_d = 1'b0;
          m_access_d   = 1'b1;
          m_addr_d     = {bus.i_addr[31:2], 2'b00};
          m_wr_en_d    = 1'b0;
          m_bytesel_d  = 4'b1111;
          m_wr_data_d  = '0;
        end
      end

      // m_ack wins over a simultaneous timeout.
      S_BUS_I: begin
        if (bus.m_ack || timeout_hit) begin
          state_d    = S_DONE;
          m_access_d = 1'b0;
          m_wr_en_d  = 1'b0;
          i_ack_d    = 1'b1;
          i_error_d  = !bus.m_ack;
          i_data_d   = bus.m_ack ? bus.m_data : '0;
        end
      end

      S_BUS_D: begin
        if (bus.m_ack || timeout_hit) begin
          state_d    = S_DONE;
          m_access_d = 1'b0;
          m_wr_en_d  = 1'b0;
          d_ack_d    = 1'b1;
          d_error_d  = !bus.m_ack;
          d_data_d   = bus.m_ack ? read_align(width_q, lane_q, bus.m_data) : '0;
        end
      end

      // Requests ignored here so a requester still holding req is not re-granted.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b0;
      width_q      <= '0;
      lane_q       <= '0;
      m_access_q   <= 1'b0;
      m_addr_q     <= '0;
      m_wr_en_q    <= 1'b0;
      m_bytesel_q  <= '0;
      m_wr_data_q  <= '0;
      i_ack_q      <= 1'b0;
      i_data_q     <= '0;
      i_error_q    <= 1'b0;
      d_ack_q      <= 1'b0;
      d_data_q     <= '0;
      d_error_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      width_q      <= width_d;
      lane_q       <= lane_d;
      m_access_q   <= m_access_d;
      m_addr_q     <= m_addr_d;
      m_wr_en_q    <= m_wr_en_d;
      m_bytesel_q  <= m_bytesel_d;
      m_wr_data_q  <= m_wr_data_d;
      i_ack_q      <= i_ack_d;
      i_data_q     <= i_data_d;
      i_error_q    <= i_error_d;
      d_ack_q      <= d_ack_d;
      d_data_q     <= d_data_d;
      d_error_q    <= d_error_d;
    end
  end

  assign bus.m_access  = m_access_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wr_en   = m_wr_en_q;
  assign bus.m_bytesel = m_bytesel_q;
  assign bus.m_wr_data = m_wr_data_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_data    = i_data_q;
  assign bus.i_error   = i_error_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_data    = d_data_q;
  assign bus.d_error   = d_error_q;

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// Self-checking bench for oldland_mem_arbiter: directed scenarios plus random
// traffic against a byte-lane arithmetic model and a round-robin model.
module tb_oldland_mem_arbiter;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  oldland_mem_arbiter_if bus ();

  oldland_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit model_last_d;   // model: 1 = data side won the most recent grant

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b10) ? 4 : (w == 2'b01) ? 2 : 1;
  endfunction

  // Byte offset of the access inside the word: address rounded down to the access size.
  function automatic int lane_off(input logic [1:0] w, input logic [31:0] addr);
    int n;
    n = nbytes(w);
    return ((addr % 4) / n) * n;
  endfunction

  function automatic logic [31:0] repl(input logic [31:0] v, input int n);
    logic [63:0] unit;
    logic [63:0] acc;
    unit = {32'h0, v} & ((64'd1 << (8 * n)) - 64'd1);
    acc  = '0;
    for (int k = 0; k < 4 / n; k++) acc = acc | (unit << (8 * n * k));
    return acc[31:0];
  endfunction

  function automatic logic [137:0] all_outs();
    return {bus.i_ack, bus.i_data, bus.i_error, bus.d_ack, bus.d_data, bus.d_error,
            bus.m_access, bus.m_addr, bus.m_wr_en, bus.m_bytesel, bus.m_wr_data};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_addr = '0; bus.d_wr_en = 0; bus.d_width = '0; bus.d_wr_data = '0;
    bus.m_ack = 0; bus.m_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_last_d = 0;
  endtask

  // Memory slave: wait for m_access, hold for dly cycles, then ack for one cycle.
  // Returns in the cycle after m_ack (where the requester ack is expected).
  task automatic serve(input int dly, input logic [31:0] rdata, input bit scramble,
                       output int lat, output logic [31:0] addr, output logic we,
                       output logic [3:0] bs, output logic [31:0] wd, output bit stable);
    lat = 0; stable = 1; addr = '0; we = 0; bs = '0; wd = '0;
    while (bus.m_access !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.m_access !== 1'b1) begin
      lat = -1;
      return;
    end
    addr = bus.m_addr; we = bus.m_wr_en; bs = bus.m_bytesel; wd = bus.m_wr_data;
    for (int c = 0; c < dly; c++) begin
      if (scramble) begin
        bus.i_req = 0; bus.d_req = 0;
        bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_wr_data = $urandom;
        bus.d_width = 2'($urandom_range(0, 3)); bus.d_wr_en = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (bus.m_access !== 1'b1 || bus.m_addr !== addr || bus.m_wr_en !== we ||
          bus.m_bytesel !== bs || bus.m_wr_data !== wd) stable = 0;
    end
    bus.m_ack = 1; bus.m_data = rdata;
    @(posedge clk); #1;
    bus.m_ack = 0; bus.m_data = $urandom;
  endtask

  // One granted transaction for the given side, with expectations from the model.
  task automatic run_xact(input string tag, input bit side_d, input int dly,
                          input logic [31:0] rdata, input int exp_lat,
                          input bit scramble, input bit drop);
    logic [31:0] e_addr, e_wd, e_rd, addr, wd;
    logic        e_we, we;
    logic [3:0]  e_bs, bs;
    logic [63:0] r64;
    int          lat, n, off;
    bit          stable;
    if (side_d) begin
      n      = nbytes(bus.d_width);
      off    = lane_off(bus.d_width, bus.d_addr);
      e_addr = bus.d_addr & ~32'd3;
      e_we   = bus.d_wr_en;
      e_bs   = 4'(((1 << n) - 1) << off);
      e_wd   = repl(bus.d_wr_data, n);
      r64    = ({32'h0, rdata} >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
      e_rd   = r64[31:0];
    end else begin
      e_addr = bus.i_addr & ~32'd3;
      e_we   = 0;
      e_bs   = 4'hF;
      e_wd   = '0;
      e_rd   = rdata;
    end

    serve(dly, rdata, scramble, lat, addr, we, bs, wd, stable);

    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s grant_latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    checks++;
    if ({addr, we, bs} !== {e_addr, e_we, e_bs}) begin
      failures++;
      $display("FAIL %s bus_ctrl: got addr=%h we=%b bs=%b expected addr=%h we=%b bs=%b",
               tag, addr, we, bs, e_addr, e_we, e_bs);
    end
    if (side_d) begin
      checks++;
      if (wd !== e_wd) begin
        failures++;
        $display("FAIL %s wr_lanes: got %h expected %h", tag, wd, e_wd);
      end
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL %s bus_hold: got unstable expected stable", tag);
    end
    checks++;
    if (side_d) begin
      if ({bus.d_ack, bus.d_error, bus.d_data, bus.i_ack, bus.m_access} !==
          {1'b1, 1'b0, e_rd, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s d_ack_cycle: got ack=%b err=%b data=%h i_ack=%b m_access=%b expected 1 0 %h 0 0",
                 tag, bus.d_ack, bus.d_error, bus.d_data, bus.i_ack, bus.m_access, e_rd);
      end
    end else begin
      if ({bus.i_ack, bus.i_error, bus.i_data, bus.d_ack, bus.m_access} !==
          {1'b1, 1'b0, e_rd, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s i_ack_cycle: got ack=%b err=%b data=%h d_ack=%b m_access=%b expected 1 0 %h 0 0",
                 tag, bus.i_ack, bus.i_error, bus.i_data, bus.d_ack, bus.m_access, e_rd);
      end
    end
    if (drop) begin
      if (side_d) bus.d_req = 0;
      else        bus.i_req = 0;
    end
    model_last_d = side_d;
    @(posedge clk); #1;
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.m_access} !== 3'b000) begin
      failures++;
      $display("FAIL %s after_ack: got i_ack=%b d_ack=%b m_access=%b expected 000",
               tag, bus.i_ack, bus.d_ack, bus.m_access);
    end
    $display("xact %s side=%s addr=%h bs=%b rd=%h lat=%0d", tag, side_d ? "D" : "I",
             addr, bs, e_rd, lat);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    bus.m_ack = 1; bus.m_data = 32'hFFFF_FFFF;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.m_access} !== 3'b000) begin
      failures++;
      $display("FAIL idle_stray_ack: got i_ack=%b d_ack=%b m_access=%b expected 000",
               bus.i_ack, bus.d_ack, bus.m_access);
    end
    bus.m_ack = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    bus.i_addr = 32'h0000_0403;
    bus.i_req  = 1;
    run_xact("fetch", 0, 1, 32'hDEAD_BEEF, 1, 0, 1);
  endtask

  task automatic test_byte_store();
    bus.d_addr = 32'h0000_1003; bus.d_width = 2'b00; bus.d_wr_en = 1;
    bus.d_wr_data = 32'h0000_00A5; bus.d_req = 1;
    run_xact("byte_store", 1, 2, $urandom, 1, 0, 1);
  endtask

  task automatic test_half_load();
    bus.d_addr = 32'h0000_2002; bus.d_width = 2'b01; bus.d_wr_en = 0;
    bus.d_wr_data = $urandom; bus.d_req = 1;
    run_xact("half_load", 1, 0, 32'h1234_5678, 1, 0, 1);
  endtask

  task automatic test_contention();
    apply_reset();
    bus.i_addr = 32'h0000_0100; bus.i_req = 1;
    bus.d_addr = 32'h8000_0204; bus.d_width = 2'b10; bus.d_wr_en = 0; bus.d_req = 1;
    for (int k = 0; k < 4; k++) begin
      // Expected order from reset: D, I, D, I.
      run_xact($sformatf("contend%0d", k), (k % 2) == 0, k % 3, $urandom, 1, 0, 0);
    end
    bus.i_req = 0; bus.d_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    bus.d_addr = 32'h0000_3001; bus.d_width = 2'b00; bus.d_wr_en = 1;
    bus.d_wr_data = 32'h0000_005A; bus.d_req = 1;
    n = 0;
    while (bus.m_access !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.m_access !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_grant: got m_access=%b expected 1", bus.m_access);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
    end
    @(negedge clk);
    rst_n = 1;
    model_last_d = 0;
    @(posedge clk); #1;
    run_xact("reset_regrant", 1, 1, $urandom, 0, 0, 1);
  endtask

  task automatic test_random();
    int  pat;
    bit  win_d;
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      pat = $urandom_range(0, 2);
      bus.i_addr    = {1'b0, 31'($urandom)};
      bus.d_addr    = {1'b1, 31'($urandom)};
      bus.d_width   = 2'($urandom_range(0, 3));
      bus.d_wr_en   = 1'($urandom_range(0, 1));
      bus.d_wr_data = $urandom;
      bus.i_req     = (pat != 1);
      bus.d_req     = (pat != 0);
      win_d = (pat == 1) || (pat == 2 && !model_last_d);
      run_xact($sformatf("rand%0d", t), win_d, $urandom_range(0, 3), $urandom, 1, pat != 2, 1);
      if (pat == 2) begin
        run_xact($sformatf("rand%0d_b", t), !win_d, $urandom_range(0, 3), $urandom, 1, 0, 1);
      end
    end
  endtask

`ifdef OLDLAND_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, hi;
    bus.d_addr = 32'h0000_0080; bus.d_width = 2'b10; bus.d_wr_en = 0; bus.d_req = 1;
    n = 0;
    while (bus.m_access !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    hi = 0;
    while (bus.m_access === 1'b1 && hi < 20) begin hi++; @(posedge clk); #1; end
    checks++;
    if (hi !== 4) begin
      failures++;
      $display("FAIL timeout_len: got %0d cycles expected 4", hi);
    end
    checks++;
    if ({bus.d_ack, bus.d_error, bus.d_data, bus.i_ack} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL timeout_ack: got ack=%b err=%b data=%h i_ack=%b expected 1 1 0 0",
               bus.d_ack, bus.d_error, bus.d_data, bus.i_ack);
    end
    bus.d_req = 0;
    model_last_d = 1;
    @(posedge clk); #1;
    bus.d_addr = 32'h0000_0084; bus.d_req = 1;
    run_xact("timeout_edge_ack", 1, 3, 32'hCAFE_F00D, 1, 0, 1);
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_fetch();
    test_byte_store();
    test_half_load();
    test_contention();
    test_reset_mid();
    test_random();
`ifdef OLDLAND_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oldland_mem_arbiter.md
Name: oldland_mem_arbiter

Overview:
Shares the single Oldland memory bus between two requesters: instruction fetch (i_*) and the load/store unit (d_*).
- Grants one transaction at a time and holds the bus until the slave acks.
- Generates byte enables from the decode-stage mem_width encoding.
- Aligns write data onto byte lanes and read data back down to bit 0.
- Sits between the fetch/LSU pipeline stages and the external memory/bus slave.

Parameters:
TIMEOUT_CYCLES, 255, cycles without m_ack before the transaction is aborted (only with OLDLAND_ARB_TIMEOUT_EN; must be >= 2, counter width = $clog2(TIMEOUT_CYCLES+1)).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_ack
i_addr  in  32  fetch address (word access, low 2 bits ignored)
i_ack  out  1  one-cycle pulse, fetch complete
i_data  out  32  fetch read data, valid with i_ack
i_error  out  1  valid with i_ack; bus timeout
d_req  in  1  LSU request; held until d_ack
d_addr  in  32  LSU byte address
d_wr_en  in  1  1 = store, 0 = load
d_width  in  2  10 = 32-bit, 01 = 16-bit, 00 = 8-bit, 11 = 8-bit
d_wr_data  in  32  store data, right-aligned
d_ack  out  1  one-cycle pulse, LSU access complete
d_data  out  32  load data, right-aligned, zero-extended
d_error  out  1  valid with d_ack; bus timeout
m_access  out  1  bus cycle active
m_addr  out  32  word-aligned address ({addr[31:2],2'b00})
m_wr_en  out  1  store
m_bytesel  out  4  byte lane enables
m_wr_data  out  32  lane-aligned store data
m_ack  in  1  slave completion
m_data  in  32  slave read data, valid with m_ack

Behaviour:
Reset (rst_n low, asynchronous, any state, including mid-transaction):
- state = IDLE, last_grant = INSTR.
- All outputs 0; m_access drops immediately.

FSM states: IDLE, BUS_I, BUS_D, DONE.
- IDLE, only d_req: go to BUS_D.
- IDLE, only i_req: go to BUS_I.
- IDLE, both requesting: round-robin; grant the side that is not last_grant (first contention after reset goes to data).
- IDLE, no requests: stay.
- Grant edge: latch address/controls into m_* registers, set m_access = 1, update last_grant.
- BUS_x: hold m_* stable while m_ack = 0. On m_ack = 1:
  - Register the aligned m_data into x_data.
  - Pulse x_ack next cycle with x_error = 0.
  - Clear m_access.
  - Go to DONE.
- DONE: x_ack high for exactly this cycle; all requests ignored; go to IDLE.
  - Prevents re-granting a request the requester has not yet dropped.

Latency:
- req seen in IDLE at cycle 0 → m_access from cycle 1.
- m_ack in cycle k → x_ack in cycle k+1.
- Zero-wait slave: ack at cycle 2; next grant no earlier than cycle 3.

Fetch transactions: m_wr_en = 0, m_bytesel = 4'b1111.

Byte enables from d_width and a = d_addr[1:0] (lane 0 = bits 7:0):
- 32-bit: 1111.
- 16-bit: a[1] ? 1100 : 0011.
- 8-bit: 0001 << a.

Write lanes (m_wr_data):
- 8-bit: byte replicated to all 4 lanes.
- 16-bit: halfword replicated to both halves.
- 32-bit: passed through.

Read data:
- Shifted right by 8*a (16-bit uses a[1] only).
- Masked to width, zero-extended.

Misalignment:
- Misaligned 32-bit accesses use the word address; a is ignored.
- A 16-bit access with a[0] = 1 uses a[1] only.

Protocol rules:
- req dropped before ack: the transaction still completes; ack is still pulsed.
- Changing request inputs after grant has no effect.
- m_ack outside BUS_I/BUS_D is ignored.

Optional Feature:
OLDLAND_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on grant and increments each BUS_x cycle without m_ack.
  - When the count reaches TIMEOUT_CYCLES: m_access drops, go to DONE, x_ack pulses with x_error = 1 and x_data = 0.
  - m_ack in the same cycle as the timeout wins: normal completion, error = 0.
- Undefined:
  - No counter; BUS_x waits indefinitely.
  - i_error/d_error are tied 0.

Test Plan:
- Fetch only, slave acks 1 cycle after m_access, m_data = 32'hDEADBEEF → m_access cycles 1-2, m_bytesel = 1111, i_ack cycle 3 with i_data = DEADBEEF, i_error = 0.
- Byte store d_addr = 0x1003, d_width = 00, d_wr_data = 0x000000A5 → m_addr = 0x1000, m_bytesel = 1000, m_wr_data = A5A5A5A5, m_wr_en = 1, d_ack once.
- Halfword load d_addr = 0x2002, m_data = 0x12345678 → m_bytesel = 1100, d_data = 0x00001234.
- i_req and d_req held high together from reset for 4 transactions → grants D, I, D, I; each ack a single pulse; one DONE cycle between transactions; no duplicate grant.
- rst_n pulsed low mid-BUS_D with m_access = 1 → m_access and all outputs 0 immediately; after release, pending d_req re-granted from IDLE.
- With OLDLAND_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, slave never acks → m_access drops after 4 cycles; d_ack with d_error = 1, d_data = 0; the next request is granted normally.
